// File: rtl/dds_ctrl_pkg.sv
// Shared types and defaults for the FSK symbol-rate controller that sequences the DDS.
package dds_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        DATA,
        TAIL
    } state_t;

    // Default words assume a 50 MHz system clock.
    localparam logic [31:0] DEF_FRQ_CH_A = 32'd154404074;
    localparam logic [31:0] DEF_FRQ_CH_B = 32'd156551558;
    localparam logic [31:0] DEF_FRQ_DEV  = 32'd206158;

    localparam int DEF_SPS       = 5208;
    localparam int DEF_GUARD_SYM = 8;

    localparam int SYM_CNT_W   = 16;
    localparam int GUARD_CNT_W = 8;

endpackage

// File: rtl/dds_sym_timer.sv
// Symbol timer: counts 0..SPS-1 while enabled, flags the first and last cycle of each symbol.
module dds_sym_timer
    import dds_ctrl_pkg::*;
#(
    parameter int SPS = DEF_SPS
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_strobe,
    output logic o_boundary
);

    localparam logic [SYM_CNT_W-1:0] LAST = SYM_CNT_W'(SPS - 1);

    logic [SYM_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + SYM_CNT_W'(1);
        end
    end

    assign o_strobe   = i_en && (r_cnt == '0);
    assign o_boundary = i_en && (r_cnt == LAST);

endmodule

// File: rtl/dds_fsk_ctrl.sv
// Two-tone FSK sequencer for the DDS: guard symbols, one data bit per symbol, guard symbols.
// Define DDS_FSK_NRZI_EN for NRZI coding (bit 0 toggles the tone); otherwise bit 1 = high tone.
module dds_fsk_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter logic [31:0] FRQ_CH_A  = DEF_FRQ_CH_A,
    parameter logic [31:0] FRQ_CH_B  = DEF_FRQ_CH_B,
    parameter logic [31:0] FRQ_DEV   = DEF_FRQ_DEV,
    parameter int          SPS       = DEF_SPS,
    parameter int          GUARD_SYM = DEF_GUARD_SYM
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_ch_sel,
    input  logic        i_bit,
    input  logic        i_bit_valid,
    input  logic        i_bit_last,
    output logic        o_bit_ready,
    output logic [31:0] o_frq_w,
    output logic        o_dds_en,
    output logic        o_sym_strobe,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_underrun
);

    localparam logic [GUARD_CNT_W-1:0] GUARD_LAST = GUARD_CNT_W'(GUARD_SYM - 1);

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [GUARD_CNT_W-1:0] r_guardCnt;
    logic [GUARD_CNT_W-1:0] w_guardCntNext;
    logic [31:0]            r_centre;
    logic                   r_toneHigh;
    logic                   r_lastSym;
    logic                   r_underrun;

    logic w_boundary;
    logic w_strobe;
    logic w_start;
    logic w_guardLast;
    logic w_transfer;
    logic w_toneNext;
    logic w_setUnderrun;

    dds_sym_timer #(
        .SPS(SPS)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (o_busy),
        .i_clr     ((r_state == IDLE) || i_abort),
        .o_strobe  (w_strobe),
        .o_boundary(w_boundary)
    );

    assign w_start     = (r_state == IDLE) && i_start && !i_abort;
    assign w_guardLast = (r_guardCnt == GUARD_LAST);
    assign w_transfer  = i_bit_valid && o_bit_ready && !i_abort;

`ifdef DDS_FSK_NRZI_EN
    assign w_toneNext = i_bit ? r_toneHigh : !r_toneHigh;
`else
    assign w_toneNext = i_bit;
`endif

    always_comb begin
        w_stateNext    = r_state;
        w_guardCntNext = r_guardCnt;
        w_setUnderrun  = 1'b0;
        o_bit_ready    = 1'b0;
        o_done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_stateNext    = HEAD;
                    w_guardCntNext = '0;
                end
            end
            HEAD: begin
                o_bit_ready = w_boundary && w_guardLast;
                if (w_boundary) begin
                    if (w_guardLast) begin
                        w_guardCntNext = '0;
                        if (i_bit_valid) begin
                            w_stateNext = DATA;
                        end else begin
                            w_setUnderrun = 1'b1;
                            w_stateNext   = TAIL;
                        end
                    end else begin
                        w_guardCntNext = r_guardCnt + GUARD_CNT_W'(1);
                    end
                end
            end
            DATA: begin
                o_bit_ready = w_boundary && !r_lastSym;
                if (w_boundary) begin
                    w_guardCntNext = '0;
                    if (r_lastSym) begin
                        w_stateNext = TAIL;
                    end else if (!i_bit_valid) begin
                        w_setUnderrun = 1'b1;
                        w_stateNext   = TAIL;
                    end
                end
            end
            TAIL: begin
                if (w_boundary) begin
                    if (w_guardLast) begin
                        o_done         = 1'b1;
                        w_stateNext    = IDLE;
                        w_guardCntNext = '0;
                    end else begin
                        w_guardCntNext = r_guardCnt + GUARD_CNT_W'(1);
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
        // Abort overrides everything, including a completing TAIL.
        if (i_abort) begin
            w_stateNext    = IDLE;
            w_guardCntNext = '0;
            w_setUnderrun  = 1'b0;
            o_done         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_guardCnt <= '0;
            r_centre   <= '0;
            r_toneHigh <= 1'b1;
            r_lastSym  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_guardCnt <= w_guardCntNext;
            if (w_start) begin
                r_centre   <= i_ch_sel ? FRQ_CH_B : FRQ_CH_A;
                r_toneHigh <= 1'b1;
                r_lastSym  <= 1'b0;
                r_underrun <= 1'b0;
            end else begin
                if (w_setUnderrun) begin
                    r_underrun <= 1'b1;
                end
                if (w_transfer) begin
                    r_toneHigh <= w_toneNext;
                    r_lastSym  <= i_bit_last;
                end
            end
        end
    end

    always_comb begin
        o_frq_w = '0;
        case (r_state)
            IDLE:    o_frq_w = '0;
            DATA:    o_frq_w = r_toneHigh ? (r_centre + FRQ_DEV) : (r_centre - FRQ_DEV);
            default: o_frq_w = r_centre;
        endcase
    end

    assign o_busy       = (r_state != IDLE);
    assign o_dds_en     = o_busy;
    assign o_sym_strobe = w_strobe;
    assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_dds_fsk_ctrl.sv
// Self-checking bench for dds_fsk_ctrl: burst table, hand-written corner sequences and
// randomized bursts compared cycle by cycle against a timeline model of a burst.
module tb_dds_fsk_ctrl;

    localparam int          SPS      = 4;
    localparam int          GUARD    = 2;
    localparam logic [31:0] CH_A     = 32'h1000;
    localparam logic [31:0] CH_B     = 32'h2000;
    localparam logic [31:0] DEV      = 32'h10;
    localparam int          HEAD_LEN = GUARD * SPS;
    localparam int          TAIL_LEN = GUARD * SPS;
    localparam int          NEVER    = 1 << 30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_abort, i_ch_sel, i_bit, i_bit_valid, i_bit_last;
    logic        o_bit_ready, o_dds_en, o_sym_strobe, o_busy, o_done, o_underrun;
    logic [31:0] o_frq_w;

    dds_fsk_ctrl #(
        .FRQ_CH_A (CH_A),
        .FRQ_CH_B (CH_B),
        .FRQ_DEV  (DEV),
        .SPS      (SPS),
        .GUARD_SYM(GUARD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_ch_sel    (i_ch_sel),
        .i_bit       (i_bit),
        .i_bit_valid (i_bit_valid),
        .i_bit_last  (i_bit_last),
        .o_bit_ready (o_bit_ready),
        .o_frq_w     (o_frq_w),
        .o_dds_en    (o_dds_en),
        .o_sym_strobe(o_sym_strobe),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_underrun  (o_underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Burst timeline model: mT counts cycles since the first HEAD cycle, data symbols follow
    // the head, and mTailStart is fixed once the burst ends by last bit or underrun.
    bit          mBusy, mUnderrun, mLastAcc, mTone;
    int          mT, mTailStart;
    logic [31:0] mCentre;
    bit          mTones[$];

    logic [31:0] sFrq;
    logic        sDone, sBusy, sXfer;

    typedef struct {
        logic            chSel;
        int              nBits;
        logic [7:0]      bits;
        int              withhold;
        int              expXfers;
        logic            expUnderrun;
        int              expDone;
        logic [3:0][31:0] expWord;
    } burst_t;

    burst_t vectors[4];

    task automatic checkValue(input string name, input logic [37:0] act, input logic [37:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %h required %h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        mBusy     = 1'b0;
        mUnderrun = 1'b0;
        mLastAcc  = 1'b0;
        mTone     = 1'b1;
        mT        = 0;
        mTailStart = NEVER;
        mTones.delete();
    endtask

    task automatic modelAccept();
`ifdef DDS_FSK_NRZI_EN
        if (!i_bit) mTone = !mTone;
`else
        mTone = i_bit;
`endif
        mTones.push_back(mTone);
        mLastAcc = i_bit_last;
    endtask

    task automatic modelStep();
        if (!mBusy) begin
            if (i_start && !i_abort) begin
                modelReset();
                mBusy   = 1'b1;
                mCentre = i_ch_sel ? CH_B : CH_A;
            end
        end else if (i_abort) begin
            mBusy = 1'b0;
        end else begin
            if (mT == HEAD_LEN - 1 ||
                (mT >= HEAD_LEN && mT < mTailStart && mT % SPS == SPS - 1)) begin
                if (mT >= HEAD_LEN && mLastAcc) begin
                    mTailStart = mT + 1;
                end else if (i_bit_valid) begin
                    modelAccept();
                end else begin
                    mUnderrun  = 1'b1;
                    mTailStart = mT + 1;
                end
            end else if (mT == mTailStart + TAIL_LEN - 1) begin
                mBusy = 1'b0;
            end
            mT++;
        end
    endtask

    task automatic checkOutput(input string name);
        logic [31:0] f;
        logic        st, rd, dn;
        f  = '0;
        st = 1'b0;
        rd = 1'b0;
        dn = 1'b0;
        if (mBusy) begin
            st = (mT % SPS == 0);
            if (mT < HEAD_LEN) begin
                f  = mCentre;
                rd = (mT == HEAD_LEN - 1);
            end else if (mT < mTailStart) begin
                f  = mTones[(mT - HEAD_LEN) / SPS] ? mCentre + DEV : mCentre - DEV;
                rd = (mT % SPS == SPS - 1) && !mLastAcc;
            end else begin
                f  = mCentre;
                dn = !i_abort && (mT == mTailStart + TAIL_LEN - 1);
            end
        end
        checkValue(name,
                   {o_frq_w, o_dds_en, o_sym_strobe, o_busy, o_done, o_underrun, o_bit_ready},
                   {f, mBusy, st, mBusy, dn, mUnderrun, rd});
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        checkOutput("outputs vs model");
        sFrq  = o_frq_w;
        sDone = o_done;
        sBusy = o_busy;
        sXfer = o_bit_ready && i_bit_valid;
        @(posedge clk);
        if (rst_n) modelStep();
        #1;
    endtask

    task automatic clearInputs();
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_bit       = 1'b0;
        i_bit_valid = 1'b0;
        i_bit_last  = 1'b0;
    endtask

    task automatic runBurst(input burst_t b, input string name);
        int          ptr, xfers, doneAt, dataLen, totalLen;
        logic [31:0] centre, expFrq;
        centre   = b.chSel ? CH_B : CH_A;
        dataLen  = b.expXfers * SPS;
        totalLen = HEAD_LEN + dataLen + TAIL_LEN;
        ptr      = 0;
        xfers    = 0;
        doneAt   = -1;
        i_ch_sel = b.chSel;
        i_start  = 1'b1;
        applyStimulus();
        i_start = 1'b0;
        for (int c = 0; c < totalLen + 2; c++) begin
            if (ptr < b.nBits && ptr != b.withhold) begin
                i_bit_valid = 1'b1;
                i_bit       = b.bits[ptr];
                i_bit_last  = (ptr == b.nBits - 1);
            end else begin
                i_bit_valid = 1'b0;
                i_bit       = 1'b0;
                i_bit_last  = 1'b0;
            end
            applyStimulus();
            if (c < HEAD_LEN)                expFrq = centre;
            else if (c < HEAD_LEN + dataLen) expFrq = b.expWord[(c - HEAD_LEN) / SPS];
            else if (c < totalLen)           expFrq = centre;
            else                             expFrq = '0;
            checkValue({name, " frq word"}, 38'(sFrq), 38'(expFrq));
            if (sDone) doneAt = c + 1;
            if (sXfer) begin
                xfers++;
                ptr++;
            end
        end
        clearInputs();
        checkValue({name, " done cycle"}, 38'(doneAt), 38'(b.expDone));
        checkValue({name, " transfers"}, 38'(xfers), 38'(b.expXfers));
        checkValue({name, " underrun"}, 38'(o_underrun), 38'(b.expUnderrun));
        checkValue({name, " idle after"}, 38'(sBusy), 38'd0);
    endtask

    initial begin
        int nBits, ptr, cycles, doneCount;
        logic curBit;

        vectors[0] = '{chSel: 1'b0, nBits: 3, bits: 8'b0000_0101, withhold: -1, expXfers: 3,
                       expUnderrun: 1'b0, expDone: 28, expWord: '0};
        vectors[1] = '{chSel: 1'b1, nBits: 4, bits: 8'b0000_1100, withhold: -1, expXfers: 4,
                       expUnderrun: 1'b0, expDone: 32, expWord: '0};
        vectors[2] = '{chSel: 1'b0, nBits: 4, bits: 8'b0000_0110, withhold: 2, expXfers: 2,
                       expUnderrun: 1'b1, expDone: 24, expWord: '0};
        vectors[3] = '{chSel: 1'b1, nBits: 1, bits: 8'b0000_0001, withhold: -1, expXfers: 1,
                       expUnderrun: 1'b0, expDone: 20, expWord: '0};
`ifdef DDS_FSK_NRZI_EN
        vectors[0].expWord[0] = 32'h1010; vectors[0].expWord[1] = 32'h0FF0; vectors[0].expWord[2] = 32'h0FF0;
        vectors[1].expWord[0] = 32'h1FF0; vectors[1].expWord[1] = 32'h2010;
        vectors[1].expWord[2] = 32'h2010; vectors[1].expWord[3] = 32'h2010;
        vectors[2].expWord[0] = 32'h0FF0; vectors[2].expWord[1] = 32'h0FF0;
`else
        vectors[0].expWord[0] = 32'h1010; vectors[0].expWord[1] = 32'h0FF0; vectors[0].expWord[2] = 32'h1010;
        vectors[1].expWord[0] = 32'h1FF0; vectors[1].expWord[1] = 32'h1FF0;
        vectors[1].expWord[2] = 32'h2010; vectors[1].expWord[3] = 32'h2010;
        vectors[2].expWord[0] = 32'h0FF0; vectors[2].expWord[1] = 32'h1010;
`endif
        vectors[3].expWord[0] = 32'h2010;

        // Reset and quiet period.
        rst_n    = 1'b0;
        i_ch_sel = 1'b0;
        clearInputs();
        modelReset();
        repeat (3) applyStimulus();
        rst_n = 1'b1;
        repeat (20) applyStimulus();
        checkValue("busy after reset", 38'(sBusy), 38'd0);

        for (int v = 0; v < 4; v++) begin
            runBurst(vectors[v], $sformatf("burst%0d", v));
            applyStimulus();
        end

        // Abort mid-DATA with a stray i_start while busy.
        i_ch_sel = 1'b0;
        i_start  = 1'b1;
        applyStimulus();
        i_start     = 1'b0;
        i_bit_valid = 1'b1;
        i_bit       = 1'b1;
        for (int c = 0; c < 14; c++) begin
            i_start = (c == 10);
            applyStimulus();
        end
        i_start = 1'b0;
        checkValue("busy before abort", 38'(sBusy), 38'd1);
        i_abort = 1'b1;
        applyStimulus();
        i_abort = 1'b0;
        i_bit_valid = 1'b0;
        doneCount = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus();
            if (c == 0) begin
                checkValue("abort busy", 38'(sBusy), 38'd0);
                checkValue("abort frq", 38'(sFrq), 38'd0);
            end
            if (sDone) doneCount++;
        end
        checkValue("abort no done", 38'(doneCount), 38'd0);

        // Async reset mid-HEAD, then start+abort together in IDLE.
        i_start = 1'b1;
        applyStimulus();
        i_start = 1'b0;
        repeat (3) applyStimulus();
        #2 rst_n = 1'b0;
        #1;
        checkValue("async reset outputs",
                   {o_frq_w, o_dds_en, o_sym_strobe, o_busy, o_done, o_underrun, o_bit_ready}, '0);
        modelReset();
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        i_start = 1'b1;
        i_abort = 1'b1;
        applyStimulus();
        clearInputs();
        repeat (4) applyStimulus();
        checkValue("start+abort idle", 38'(sBusy), 38'd0);

        // Randomized bursts with random gaps, valid drops, stray starts and rare aborts.
        for (int b = 0; b < 30; b++) begin
            repeat ($urandom_range(0, 3)) applyStimulus();
            nBits    = $urandom_range(1, 5);
            ptr      = 0;
            curBit   = 1'($urandom_range(0, 1));
            i_ch_sel = 1'($urandom_range(0, 1));
            i_start  = 1'b1;
            i_abort  = ($urandom_range(0, 9) == 0);
            applyStimulus();
            i_start = 1'b0;
            i_abort = 1'b0;
            cycles  = 0;
            while (mBusy && cycles < 400) begin
                i_start     = ($urandom_range(0, 19) == 0);
                i_abort     = ($urandom_range(0, 149) == 0);
                i_bit_valid = (ptr < nBits) && ($urandom_range(0, 7) != 0);
                i_bit       = curBit;
                i_bit_last  = (ptr == nBits - 1);
                applyStimulus();
                if (sXfer) begin
                    ptr++;
                    curBit = 1'($urandom_range(0, 1));
                end
                cycles++;
            end
            clearInputs();
            checkValue("random burst bounded", 38'(cycles >= 400), 38'd0);
        end
        applyStimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_fsk_ctrl.md
Name: dds_fsk_ctrl

Overview:
- Symbol-rate controller that sequences a programmable-word phase-accumulator DDS as a 2-tone FSK modulator for the AIS transmit path.
- Accepts a serial bit stream over a valid/ready handshake and selects channel A/B centre frequency.
- Drives the DDS frequency control word once per symbol (centre ± deviation), framed by guard symbols at centre frequency.
- Sits between the AIS framer (bit source) and the DDS (sin/cos ROM lookup).

Parameters:
- FRQ_CH_A, 32'd154404074, channel A centre frequency control word.
- FRQ_CH_B, 32'd156551558, channel B centre word (A + 25 kHz at 50 MHz clk).
- FRQ_DEV, 32'd206158, tone deviation word (2.4 kHz at 50 MHz).
- SPS, 5208, clock cycles per symbol (9600 Bd at 50 MHz); legal range 2..65535.
- GUARD_SYM, 8, centre-frequency symbols before the first data bit and after the last; legal range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_start  in  1  1-cycle pulse: begin a burst (honoured only in IDLE)
- i_abort  in  1  synchronous abort: return to IDLE next cycle
- i_ch_sel  in  1  0 = channel A, 1 = channel B; sampled on accepted i_start
- i_bit  in  1  data bit
- i_bit_valid  in  1  i_bit and i_bit_last valid
- i_bit_last  in  1  marks final bit of burst
- o_bit_ready  out  1  bit accepted when i_bit_valid & o_bit_ready
- o_frq_w  out  32  DDS frequency control word
- o_dds_en  out  1  DDS accumulator enable / TX gate
- o_sym_strobe  out  1  1-cycle pulse on first cycle of every symbol while busy
- o_busy  out  1  high in any state but IDLE
- o_done  out  1  1-cycle pulse when TAIL completes normally
- o_underrun  out  1  sticky: bit not valid at a symbol boundary; cleared on next accepted i_start

Behaviour:
- Reset: every output 0; state IDLE; sym counter 0; guard counter 0; tone state = high.
- States: IDLE, HEAD, DATA, TAIL. Symbol counter cnt runs 0..SPS-1 in HEAD/DATA/TAIL; boundary = (cnt == SPS-1).
- IDLE: o_dds_en = 0, o_frq_w = 0. On i_start (and not i_abort): latch centre = i_ch_sel ? FRQ_CH_B : FRQ_CH_A; clear o_underrun; tone state = high. Next cycle: HEAD, cnt = 0, o_dds_en = 1, o_frq_w = centre, o_sym_strobe = 1.
- HEAD: GUARD_SYM symbols at centre.
  - o_bit_ready = 1 only at the boundary of the last HEAD symbol.
  - Transfer → DATA. No transfer → set o_underrun, go TAIL.
- DATA: o_frq_w = centre + FRQ_DEV (tone high) or centre - FRQ_DEV (tone low); mod-2^32 wrap.
  - o_bit_ready = 1 at each boundary unless the current symbol carries i_bit_last.
  - New word appears on the first cycle of the next symbol: 1-cycle latency from the transfer, coincident with o_sym_strobe.
  - Boundary with no valid bit → o_underrun = 1, TAIL.
  - Boundary of the last-bit symbol → TAIL.
- TAIL: GUARD_SYM symbols at centre; o_bit_ready = 0. At the final boundary → IDLE; o_done = 1 for that one cycle; o_dds_en = 0 and o_frq_w = 0 from the next cycle.
- i_abort in any state: next cycle IDLE, outputs as in reset (o_underrun kept), no o_done.
- i_abort together with i_start in IDLE: abort wins.
- i_start while busy: ignored.
- i_bit_valid outside a ready cycle: ignored; the source must hold the bit.
- Async reset mid-burst: immediate IDLE, all outputs 0.

Optional Feature:
- Macro DDS_FSK_NRZI_EN defined (AIS mode): NRZI coding. Accepted bit 0 toggles the tone; bit 1 keeps it. Tone starts high for each burst.
- Macro absent: direct mapping, bit 1 → centre + FRQ_DEV, bit 0 → centre - FRQ_DEV.

Decomposition:
- Package dds_ctrl_pkg holds:
  - state enum (IDLE, HEAD, DATA, TAIL);
  - default channel/deviation words;
  - counter width constant (16 bits for SPS, 8 bits for GUARD_SYM).
- One sub-module, dds_sym_timer: free cycle counter with enable and sync clear, emitting boundary and strobe.

Test Plan (SPS=4, GUARD_SYM=2, 32'h1000 centre A, 32'h2000 centre B, FRQ_DEV=32'h10):
- Reset release, no stimulus → all outputs 0 for 20 cycles; o_busy = 0.
- i_start with ch_sel=0, then bits 1,0,1(last) valid, NRZI off → o_frq_w sequence:
  - 8 cycles 32'h1000;
  - 4 cycles each 32'h1010, 32'h0FF0, 32'h1010;
  - 8 cycles 32'h1000;
  - o_done pulse on cycle 28 after first HEAD cycle; exactly 3 transfers.
- DDS_FSK_NRZI_EN, ch_sel=1, bits 0,0,1,1(last) → tones low, high, high, high → words 32'h1FF0, 32'h2010, 32'h2010, 32'h2010.
- Withhold i_bit_valid at second DATA boundary → o_underrun = 1, 8 guard cycles at centre, then IDLE; o_underrun cleared by the next i_start.
- i_abort mid-DATA, plus i_start asserted while busy → IDLE the next cycle, o_dds_en = 0, no o_done; mid-burst i_start has no effect.
- Assert rst_n low mid-HEAD, then i_start same cycle as i_abort in IDLE → outputs 0 asynchronously; controller remains IDLE.
